// File: rtl/pattern_tx.sv
// pattern_tx: serial pattern transmitter that sends PATTERN MSB-first on j, repeated count times.
// Optional build macro PATTERN_TX_PARITY_EN appends an even-parity bit to each repetition. Rev 1.0
`default_nettype none

module pattern_tx #(
  parameter int               PAT_W   = 5,
  parameter logic [PAT_W-1:0] PATTERN = 5'b10010,
  parameter int               CNT_W   = 4,
  parameter int               GAP_LEN = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [CNT_W-1:0] count,
  input  logic             stop,
  output logic             j,
  output logic             valid,
  output logic             busy,
  output logic             done
);

  localparam int BW = $clog2(PAT_W + 1);
  localparam int GW = (GAP_LEN > 1) ? $clog2(GAP_LEN) : 1;

  localparam logic             FIRST_BIT = PATTERN[PAT_W-1];
  localparam logic [PAT_W-1:0] LOAD_SH   = {PATTERN[PAT_W-2:0], 1'b0};
  localparam logic [GW-1:0]    GAP_LAST  = GW'((GAP_LEN > 0) ? GAP_LEN - 1 : 0);
`ifdef PATTERN_TX_PARITY_EN
  localparam logic             PARITY    = ^PATTERN;
  localparam logic [BW-1:0]    PAR_IDX   = BW'(PAT_W - 1);
  localparam logic [BW-1:0]    BIT_LAST  = BW'(PAT_W);
`else
  localparam logic [BW-1:0]    BIT_LAST  = BW'(PAT_W - 1);
`endif

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    GAP  = 2'd2,
    DONE = 2'd3
  } state_t;

  state_t           state, state_n;
  logic [PAT_W-1:0] shreg, shreg_n;
  logic [BW-1:0]    bit_cnt, bit_n;
  logic [CNT_W-1:0] rep_cnt, rep_n;
  logic [GW-1:0]    gap_cnt, gap_n;
  logic             j_n, valid_n, busy_n, done_n;
  logic [CNT_W-1:0] rep_left;

  // saturating decrement: the rep counter never wraps
  assign rep_left = (rep_cnt != '0) ? rep_cnt - 1'b1 : '0;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state   <= IDLE;
      shreg   <= '0;
      bit_cnt <= '0;
      rep_cnt <= '0;
      gap_cnt <= '0;
      j       <= 1'b0;
      valid   <= 1'b0;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_n;
      shreg   <= shreg_n;
      bit_cnt <= bit_n;
      rep_cnt <= rep_n;
      gap_cnt <= gap_n;
      j       <= j_n;
      valid   <= valid_n;
      busy    <= busy_n;
      done    <= done_n;
    end
  end

  // Outputs are computed as next-state values so they leave the flops with the state.
  always_comb begin
    state_n = state;
    shreg_n = shreg;
    bit_n   = bit_cnt;
    rep_n   = rep_cnt;
    gap_n   = gap_cnt;
    j_n     = 1'b0;
    valid_n = 1'b0;
    busy_n  = 1'b0;
    done_n  = 1'b0;

    case (state)
      IDLE: begin
        if (start) begin
          rep_n   = count;
          shreg_n = LOAD_SH;
          bit_n   = '0;
          gap_n   = '0;
          if (count != '0) begin
            state_n = SEND;
            j_n     = FIRST_BIT;
            valid_n = 1'b1;
            busy_n  = 1'b1;
          end else begin
            state_n = DONE;
            done_n  = 1'b1;
          end
        end
      end

      SEND: begin
        if (stop) begin
          state_n = IDLE;
        end else if (bit_cnt != BIT_LAST) begin
          bit_n   = bit_cnt + 1'b1;
          valid_n = 1'b1;
          busy_n  = 1'b1;
          j_n     = shreg[PAT_W-1];
          shreg_n = {shreg[PAT_W-2:0], 1'b0};
`ifdef PATTERN_TX_PARITY_EN
          if (bit_cnt == PAR_IDX) j_n = PARITY;
`endif
        end else begin
          rep_n = rep_left;
          if (GAP_LEN > 0) begin
            state_n = GAP;
            gap_n   = '0;
            busy_n  = 1'b1;
          end else if (rep_left != '0) begin
            shreg_n = LOAD_SH;
            bit_n   = '0;
            j_n     = FIRST_BIT;
            valid_n = 1'b1;
            busy_n  = 1'b1;
          end else begin
            state_n = DONE;
            done_n  = 1'b1;
          end
        end
      end

      GAP: begin
        if (stop) begin
          state_n = IDLE;
        end else if (gap_cnt == GAP_LAST) begin
          if (rep_cnt != '0) begin
            state_n = SEND;
            shreg_n = LOAD_SH;
            bit_n   = '0;
            j_n     = FIRST_BIT;
            valid_n = 1'b1;
            busy_n  = 1'b1;
          end else begin
            state_n = DONE;
            done_n  = 1'b1;
          end
        end else begin
          gap_n  = gap_cnt + 1'b1;
          busy_n = 1'b1;
        end
      end

      DONE: state_n = IDLE;

      default: state_n = IDLE;
    endcase
  end

endmodule

`default_nettype wire

// File: tb/tb_pattern_tx.sv
// tb_pattern_tx: scoreboard bench for pattern_tx; one back-to-back instance and one with a 2-cycle gap.
`default_nettype none

module tb_pattern_tx;

  localparam int PW = 5;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          start0 = 1'b0, stop0 = 1'b0, start1 = 1'b0, stop1 = 1'b0;
  logic [CW-1:0] count0 = '0, count1 = '0;
  logic          j0, v0, b0, d0, j1, v1, b1, d1;

  logic [7:0]    expq[$];
  int            compared   = 0;
  int            mismatched = 0;
  logic [PW-1:0] pat = 5'b10010;

  pattern_tx #(.PAT_W(PW), .PATTERN(5'b10010), .CNT_W(CW), .GAP_LEN(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .count(count0), .stop(stop0),
    .j(j0), .valid(v0), .busy(b0), .done(d0)
  );

  pattern_tx #(.PAT_W(PW), .PATTERN(5'b10010), .CNT_W(CW), .GAP_LEN(2)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .count(count1), .stop(stop1),
    .j(j1), .valid(v1), .busy(b1), .done(d1)
  );

  always #5 clk = ~clk;

  // expected output nibble is {j, valid, busy, done}
  function automatic logic [3:0] bitv(input logic b);
    return {b, 3'b110};
  endfunction

  task automatic push(input logic [3:0] e0, input logic [3:0] e1);
    expq.push_back({e0, e1});
  endtask

  task automatic push_rep(input int which);
    for (int i = PW - 1; i >= 0; i--) begin
      if (which == 0) push(bitv(pat[i]), 4'b0000);
      else            push(4'b0000, bitv(pat[i]));
    end
`ifdef PATTERN_TX_PARITY_EN
    if (which == 0) push(bitv(^pat), 4'b0000);
    else            push(4'b0000, bitv(^pat));
`endif
  endtask

  task automatic push_gap();
    push(4'b0000, 4'b0010);
    push(4'b0000, 4'b0010);
  endtask

  task automatic cmp(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic tick(input string tag);
    logic [7:0] e;
    @(posedge clk);
    @(negedge clk);
    if (expq.size() == 0) begin
      e = 8'hxx;
      compared++;
      mismatched++;
      $error("FAIL %s scoreboard empty observed=%b", tag, {j0, v0, b0, d0, j1, v1, b1, d1});
    end else begin
      e = expq.pop_front();
      cmp(tag, {j0, v0, b0, d0, j1, v1, b1, d1}, e);
    end
  endtask

  task automatic drain(input string tag);
    while (expq.size() > 0) tick(tag);
  endtask

  initial begin
    // reset held with toggling inputs
    for (int i = 0; i < 3; i++) push(4'b0000, 4'b0000);
    for (int i = 0; i < 3; i++) begin
      start0 = 1'($urandom_range(0, 1));
      stop0  = 1'($urandom_range(0, 1));
      start1 = 1'($urandom_range(0, 1));
      count0 = 4'($urandom_range(0, 15));
      tick("reset");
    end
    start0 = 1'b0; stop0 = 1'b0; start1 = 1'b0; count0 = '0;
    rst = 1'b1;
    push(4'b0000, 4'b0000);
    push(4'b0000, 4'b0000);
    drain("idle");

    // single repetition
    count0 = 4'd1; start0 = 1'b1;
    push_rep(0); push(4'b0001, 4'b0000); push(4'b0000, 4'b0000);
    tick("rep1"); start0 = 1'b0;
    drain("rep1");

    // three back-to-back repetitions
    count0 = 4'd3; start0 = 1'b1;
    for (int r = 0; r < 3; r++) push_rep(0);
    push(4'b0001, 4'b0000); push(4'b0000, 4'b0000);
    tick("rep3"); start0 = 1'b0;
    drain("rep3");

    // three repetitions with guard gaps
    count1 = 4'd3; start1 = 1'b1;
    for (int r = 0; r < 3; r++) begin push_rep(1); push_gap(); end
    push(4'b0000, 4'b0001); push(4'b0000, 4'b0000);
    tick("gap3"); start1 = 1'b0;
    drain("gap3");

    // zero repetitions
    count0 = 4'd0; start0 = 1'b1;
    push(4'b0001, 4'b0000); push(4'b0000, 4'b0000);
    tick("cnt0"); start0 = 1'b0;
    drain("cnt0");

    // start held while busy, then stop on third bit
    count0 = 4'd2; start0 = 1'b1;
    push(bitv(pat[4]), 4'b0000); push(bitv(pat[3]), 4'b0000); push(bitv(pat[2]), 4'b0000);
    push(4'b0000, 4'b0000); push(4'b0000, 4'b0000);
    tick("stop"); tick("stop"); tick("stop");
    start0 = 1'b0; stop0 = 1'b1;
    tick("stop"); stop0 = 1'b0;
    drain("stop");

    // start and stop together in IDLE: start wins
    count1 = 4'd1; start1 = 1'b1; stop1 = 1'b1;
    push_rep(1); push_gap(); push(4'b0000, 4'b0001); push(4'b0000, 4'b0000);
    tick("startstop"); start1 = 1'b0; stop1 = 1'b0;
    drain("startstop");

    // maximum repetition count
    count0 = 4'd15; start0 = 1'b1;
    for (int r = 0; r < 15; r++) push_rep(0);
    push(4'b0001, 4'b0000); push(4'b0000, 4'b0000);
    tick("cntmax"); start0 = 1'b0;
    drain("cntmax");

    // asynchronous reset mid-pattern
    count0 = 4'd1; start0 = 1'b1;
    push(bitv(pat[4]), 4'b0000); push(bitv(pat[3]), 4'b0000);
    tick("arst"); start0 = 1'b0;
    tick("arst");
    #2 rst = 1'b0;
    #1 cmp("arst_now", {j0, v0, b0, d0, j1, v1, b1, d1}, 8'h00);
    @(negedge clk) rst = 1'b1;
    for (int i = 0; i < 3; i++) push(4'b0000, 4'b0000);
    drain("arst_after");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule

`default_nettype wire
